// File: rtl/raw_frame_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : raw_frame_timing_gen
// Brief    : Drains a valid/ready pixel stream and regenerates fval/lval
//            camera framing with fixed line blanking and frame lead/trail.
// Revision : 1.0 - initial release
// ============================================================================
module raw_frame_timing_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 80,
  parameter int V_ACTIVE   = 512,
  parameter int FV_LEAD    = 2,
  parameter int FV_TRAIL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  b_fval,
  output logic                  b_lval,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done,
  output logic                  underflow
);

  localparam int c_MAX_A = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int c_MAX_B = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
  localparam int c_H_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_HW    = (c_H_MAX > 1) ? $clog2(c_H_MAX) : 1;
  localparam int c_VW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [c_HW-1:0] c_LEAD_LAST  = c_HW'(FV_LEAD - 1);
  localparam logic [c_HW-1:0] c_ACT_LAST   = c_HW'(H_ACTIVE - 1);
  localparam logic [c_HW-1:0] c_BLK_LAST   = c_HW'(H_BLANK - 1);
  localparam logic [c_HW-1:0] c_TRAIL_LAST = c_HW'(FV_TRAIL - 1);
  localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_V_PRE    = 3'd1,
    S_LINE_ACT = 3'd2,
    S_LINE_BLK = 3'd3,
    S_V_POST   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_HW-1:0]       r_h_cnt;
  logic [c_HW-1:0]       w_h_cnt_nxt;
  logic [c_VW-1:0]       r_v_cnt;
  logic [c_VW-1:0]       w_v_cnt_nxt;
  logic                  r_fval;
  logic                  r_fval_d;
  logic                  r_lval;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_frame_done;
  logic                  r_underflow;
  logic                  w_start_ok;

  assign w_start_ok = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    w_h_cnt_nxt = r_h_cnt + 1'b1;
    w_v_cnt_nxt = r_v_cnt;
    case (r_state)
      S_IDLE: begin
        w_h_cnt_nxt = '0;
        w_v_cnt_nxt = '0;
        if (start) w_state_nxt = S_V_PRE;
      end
      S_V_PRE: begin
        if (r_h_cnt == c_LEAD_LAST) begin
          w_state_nxt = S_LINE_ACT;
          w_h_cnt_nxt = '0;
        end
      end
      S_LINE_ACT: begin
        if (r_h_cnt == c_ACT_LAST) begin
          w_state_nxt = S_LINE_BLK;
          w_h_cnt_nxt = '0;
        end
      end
      S_LINE_BLK: begin
        if (r_h_cnt == c_BLK_LAST) begin
          w_h_cnt_nxt = '0;
          if (r_v_cnt == c_V_LAST) begin
            w_state_nxt = S_V_POST;
            w_v_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_LINE_ACT;
            w_v_cnt_nxt = r_v_cnt + 1'b1;
          end
        end
      end
      S_V_POST: begin
        if (r_h_cnt == c_TRAIL_LAST) begin
          w_state_nxt = S_IDLE;
          w_h_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_h_cnt_nxt = '0;
        w_v_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_cnt_nxt;
      r_v_cnt <= w_v_cnt_nxt;
    end
  end

  // Outputs trail the state by one cycle; frame_done is a delayed fall detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fval       <= 1'b0;
      r_fval_d     <= 1'b0;
      r_lval       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_fval       <= (r_state != S_IDLE);
      r_fval_d     <= r_fval;
      r_lval       <= (r_state == S_LINE_ACT);
      r_data       <= ((r_state == S_LINE_ACT) && pix_valid) ? pix_data : '0;
      r_frame_done <= r_fval_d && !r_fval;
      if (w_start_ok)
        r_underflow <= 1'b0;
      else if ((r_state == S_LINE_ACT) && !pix_valid)
        r_underflow <= 1'b1;
    end
  end

  assign pix_ready  = (r_state == S_LINE_ACT);
  assign b_fval     = r_fval;
  assign b_lval     = r_lval;
  assign out_data   = r_data;
  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_raw_frame_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_frame_timing_gen
// Brief    : Self-checking bench for raw_frame_timing_gen (small frame geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_raw_frame_timing_gen;

  localparam int c_DW    = 16;
  localparam int c_ACT   = 8;
  localparam int c_BLK   = 4;
  localparam int c_LINES = 3;
  localparam int c_LEAD  = 2;
  localparam int c_TRAIL = 2;
  localparam int c_LINE  = c_ACT + c_BLK;
  localparam int c_FRAME = c_LEAD + c_LINES * c_LINE + c_TRAIL;
  localparam int c_LAST_J = c_FRAME + 6;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [c_DW-1:0] pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic            b_fval;
  logic            b_lval;
  logic [c_DW-1:0] out_data;
  logic            frame_done;
  logic            underflow;

  int   errors = 0;
  int   checks = 0;
  logic exp_uf = 1'b0;

  raw_frame_timing_gen #(
    .DATA_WIDTH(c_DW), .H_ACTIVE(c_ACT), .H_BLANK(c_BLK),
    .V_ACTIVE(c_LINES), .FV_LEAD(c_LEAD), .FV_TRAIL(c_TRAIL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .b_fval(b_fval),
    .b_lval(b_lval), .out_data(out_data), .frame_done(frame_done),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame offset m counts cycles from the first V_PRE cycle.
  function automatic bit is_active(input int m);
    return (m >= c_LEAD) && (m < c_LEAD + c_LINES * c_LINE) &&
           (((m - c_LEAD) % c_LINE) < c_ACT);
  endfunction

  function automatic bit in_frame(input int m);
    return (m >= 0) && (m < c_FRAME);
  endfunction

  // Runs one frame from IDLE; j counts rising edges since start was driven.
  // mode 0: incrementing data, 1: one drop at line 1 pixel 3,
  // 2: extra start pulses, 3: random data and valid. abort_j<0 means no abort.
  task automatic run_frame(input int mode, input int abort_j,
                           output int cons_obs, output int cons_exp);
    logic [c_DW-1:0] exp_d;
    logic [c_DW-1:0] seq;
    logic            v;
    logic [c_DW-1:0] d;
    bit              a;
    exp_d    = '0;
    seq      = '0;
    cons_obs = 0;
    cons_exp = 0;
    for (int j = 0; j <= c_LAST_J; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == abort_j) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_fval !== 1'b0 || b_lval !== 1'b0 || out_data !== '0) begin
          errors++;
          $display("FAIL async_reset: fval=%b lval=%b data=%h required 0/0/0",
                   b_fval, b_lval, out_data);
        end
        checks++;
        if (pix_ready !== 1'b0 || underflow !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_misc: ready=%b uf=%b done=%b required 0/0/0",
                   pix_ready, underflow, frame_done);
        end
        return;
      end
      checks++;
      if (b_fval !== in_frame(j - 2)) begin
        errors++;
        $display("FAIL b_fval j=%0d: got %b required %b", j, b_fval, in_frame(j - 2));
      end
      checks++;
      if (b_lval !== is_active(j - 2)) begin
        errors++;
        $display("FAIL b_lval j=%0d: got %b required %b", j, b_lval, is_active(j - 2));
      end
      checks++;
      if (out_data !== exp_d) begin
        errors++;
        $display("FAIL out_data j=%0d: got %h required %h", j, out_data, exp_d);
      end
      checks++;
      if (pix_ready !== is_active(j - 1)) begin
        errors++;
        $display("FAIL pix_ready j=%0d: got %b required %b", j, pix_ready, is_active(j - 1));
      end
      checks++;
      if (frame_done !== (j == c_FRAME + 3)) begin
        errors++;
        $display("FAIL frame_done j=%0d: got %b required %b", j, frame_done, (j == c_FRAME + 3));
      end
      checks++;
      if (underflow !== exp_uf) begin
        errors++;
        $display("FAIL underflow j=%0d: got %b required %b", j, underflow, exp_uf);
      end

      // Drive the inputs that the next rising edge will sample.
      start = (j == 0) || (mode == 2 && (j == 6 || j == c_FRAME - 1 || j == c_FRAME));
      case (mode)
        1:       begin v = (j != 18); d = seq; end
        3:       begin v = ($urandom_range(0, 3) != 0); d = c_DW'($urandom); end
        default: begin v = 1'b1; d = seq; end
      endcase
      if (j >= c_FRAME + 1) v = 1'b0;
      pix_valid = v;
      pix_data  = d;
      if (pix_ready && pix_valid) cons_obs++;

      a = is_active(j - 1);
      exp_d = (a && v) ? d : '0;
      if (a && v) begin
        cons_exp++;
        seq++;
      end
      if (j == 0) exp_uf = 1'b0;
      if (a && !v) exp_uf = 1'b1;
    end
    start     = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b_fval, b_lval, out_data, frame_done, underflow, pix_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: fval=%b lval=%b data=%h done=%b uf=%b ready=%b required all 0",
               b_fval, b_lval, out_data, frame_done, underflow, pix_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    int bad = 0;
    pix_valid = 1'b1;
    pix_data  = 16'hBEEF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if ({b_fval, b_lval, out_data, frame_done, underflow, pix_ready} !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d bad cycles required 0", bad);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_frame_basic();
    int co, ce;
    run_frame(0, -1, co, ce);
    checks++;
    if (co != ce || ce != c_LINES * c_ACT) begin
      errors++;
      $display("FAIL basic_consumed: got %0d required %0d", co, c_LINES * c_ACT);
    end
  endtask

  task automatic test_underflow();
    int co, ce;
    run_frame(1, -1, co, ce);
    checks++;
    if (co != ce || ce != c_LINES * c_ACT - 1) begin
      errors++;
      $display("FAIL uf_consumed: got %0d required %0d", co, c_LINES * c_ACT - 1);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: got %b required 1", underflow);
    end
  endtask

  task automatic test_restart_ignored();
    int co, ce;
    run_frame(2, -1, co, ce);
    checks++;
    if (co != ce) begin
      errors++;
      $display("FAIL restart_consumed: got %0d required %0d", co, ce);
    end
  endtask

  task automatic test_reset_midframe();
    int co, ce;
    run_frame(0, c_LEAD + c_LINE + 5 + 1, co, ce);
    start = 1'b0; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_uf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b_fval, b_lval, out_data, frame_done} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: fval=%b lval=%b data=%h done=%b required 0",
               b_fval, b_lval, out_data, frame_done);
    end
    run_frame(0, -1, co, ce);
  endtask

  task automatic test_random_frames();
    int co, ce;
    for (int n = 0; n < 3; n++) begin
      run_frame(3, -1, co, ce);
      checks++;
      if (co != ce) begin
        errors++;
        $display("FAIL random_consumed: got %0d required %0d", co, ce);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame_basic();
    test_underflow();
    test_restart_ignored();
    test_reset_midframe();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
